// File: rtl/char_queue_8x9_pkg.sv
// Shared constants and helpers for the 8x9 SpaceWire character queue.
package char_queue_8x9_pkg;

  localparam int QUEUE_DEPTH = 8;
  localparam int QUEUE_WIDTH = 9;
  localparam int PTR_W       = 3;

  localparam logic [1:0] CODE_FCT = 2'b00;
  localparam logic [1:0] CODE_EOP = 2'b01;
  localparam logic [1:0] CODE_EEP = 2'b10;
  localparam logic [1:0] CODE_ESC = 2'b11;

  typedef logic [PTR_W-1:0]       ptr_t;
  typedef logic [QUEUE_WIDTH-1:0] word_t;

  // Only data chars and packet terminators are worth buffering; FCT/ESC are link-level.
  function automatic logic keep_char(input logic nchar, input logic lchar,
                                     input logic [1:0] code);
    return nchar | (lchar & ((code == CODE_EOP) | (code == CODE_EEP)));
  endfunction

endpackage

// File: rtl/char_queue_8x9_if.sv
// Decoder write side plus Wishbone pipelined read side of the character queue.
interface char_queue_8x9_if;
  import char_queue_8x9_pkg::*;

  logic       nchar;
  logic       lchar;
  logic [7:0] char_i;
  logic       stb_i;
  logic       ack_o;
  word_t      dat_o;

  modport master (output nchar, lchar, char_i, stb_i, input  ack_o, dat_o);
  modport slave  (input  nchar, lchar, char_i, stb_i, output ack_o, dat_o);

endinterface

// File: rtl/char_queue_regfile.sv
// 8x9 storage: synchronous write, asynchronous read. Contents are never reset.
module char_queue_regfile
  import char_queue_8x9_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  ptr_t  waddr,
  input  word_t wdata,
  input  ptr_t  raddr,
  output word_t rdata
);

  word_t mem [QUEUE_DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/char_queue_8x9.sv
// 8-entry character FIFO between the SpaceWire decoder and a Wishbone read port.
// Optional sticky overrun flag when built with CHAR_QUEUE_OVERRUN_EN.
module char_queue_8x9
  import char_queue_8x9_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  char_queue_8x9_if.slave        bus,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [QUEUE_DEPTH-1:0] occupied_tb,
  output ptr_t                   rp_tb,
  output ptr_t                   wp_tb,
  output logic                   we_tb
`ifdef CHAR_QUEUE_OVERRUN_EN
  ,
  output logic                   overrun_o
`endif
);

  logic [QUEUE_DEPTH-1:0] occupied, occ_next;
  ptr_t  rp, wp;
  logic  ack, we, pop, push, full, empty;
  word_t word;

  assign we    = keep_char(bus.nchar, bus.lchar, bus.char_i[1:0]);
  assign word  = {bus.lchar & ~bus.nchar, bus.char_i};
  assign full  = &occupied;
  assign empty = ~|occupied;
  assign pop   = ack & ~empty;
  // A pop on the same edge frees a slot, so a full queue still accepts.
  assign push  = we & (~full | pop);

  // Set after clear: a simultaneous pop/push on one slot leaves it occupied.
  always_comb begin
    occ_next = occupied;
    if (pop)  occ_next[rp] = 1'b0;
    if (push) occ_next[wp] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupied <= '0;
      rp       <= '0;
      wp       <= '0;
      ack      <= 1'b0;
    end else begin
      occupied <= occ_next;
      ack      <= bus.stb_i;
      if (pop)  rp <= rp + 3'd1;
      if (push) wp <= wp + 3'd1;
    end
  end

  char_queue_regfile u_regfile (
    .clk   (clk),
    .we    (push),
    .waddr (wp),
    .wdata (word),
    .raddr (rp),
    .rdata (bus.dat_o)
  );

`ifdef CHAR_QUEUE_OVERRUN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  overrun_o <= 1'b0;
    else if (we & full & ~pop)   overrun_o <= 1'b1;
  end
`endif

  assign bus.ack_o   = ack;
  assign full_o      = full;
  assign empty_o     = empty;
  assign occupied_tb = occupied;
  assign rp_tb       = rp;
  assign wp_tb       = wp;
  assign we_tb       = we;

endmodule

// File: tb/tb_char_queue_8x9.sv
// Directed plus random bench for char_queue_8x9 against a queue-based reference model.
module tb_char_queue_8x9;
  import char_queue_8x9_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       full_o, empty_o, we_tb;
  logic [7:0] occupied_tb;
  logic [2:0] rp_tb, wp_tb;
`ifdef CHAR_QUEUE_OVERRUN_EN
  logic       overrun_o;
`endif

  char_queue_8x9_if bus();

  char_queue_8x9 dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .occupied_tb (occupied_tb),
    .rp_tb       (rp_tb),
    .wp_tb       (wp_tb),
    .we_tb       (we_tb)
`ifdef CHAR_QUEUE_OVERRUN_EN
    ,
    .overrun_o   (overrun_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of words plus pointer counters.
  logic [8:0] mq[$];
  int         m_rp, m_wp;
  bit         m_ack, m_ovr;
  int         tests, fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_we();
    return bus.nchar || (bus.lchar && (bus.char_i[1:0] == 2'd1 || bus.char_i[1:0] == 2'd2));
  endfunction

  task automatic m_clear();
    mq.delete();
    m_rp = 0; m_wp = 0; m_ack = 0; m_ovr = 0;
  endtask

  task automatic check_all();
    logic [7:0] occ;
    occ = '0;
    for (int i = 0; i < mq.size(); i++) occ[(m_rp + i) % 8] = 1'b1;
    chk("ack",      32'(bus.ack_o),   32'(m_ack));
    chk("rp",       32'(rp_tb),       32'(m_rp));
    chk("wp",       32'(wp_tb),       32'(m_wp));
    chk("occupied", 32'(occupied_tb), 32'(occ));
    chk("full",     32'(full_o),      32'(mq.size() == 8));
    chk("empty",    32'(empty_o),     32'(mq.size() == 0));
    chk("we",       32'(we_tb),       32'(m_we()));
    if (mq.size() > 0) chk("dat", 32'(bus.dat_o), 32'(mq[0]));
`ifdef CHAR_QUEUE_OVERRUN_EN
    chk("overrun",  32'(overrun_o),   32'(m_ovr));
`endif
  endtask

  task automatic tick();
    bit pop, we, acc;
    @(posedge clk);
    pop = m_ack && (mq.size() > 0);
    we  = m_we();
    acc = we && (mq.size() < 8 || pop);
    if (we && mq.size() == 8 && !pop) m_ovr = 1;
    if (pop) begin void'(mq.pop_front()); m_rp = (m_rp + 1) % 8; end
    if (acc) begin mq.push_back({bus.lchar & ~bus.nchar, bus.char_i}); m_wp = (m_wp + 1) % 8; end
    m_ack = bus.stb_i;
    #1;
    check_all();
  endtask

  task automatic drive(input logic n, input logic l, input logic [7:0] c, input logic s);
    bus.nchar = n; bus.lchar = l; bus.char_i = c; bus.stb_i = s;
  endtask

  // Assert reset between edges, check immediate clear, release before the next edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    m_clear();
    check_all();
    chk("rst_empty", 32'(empty_o), 32'd1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0;
    drive(0, 0, 8'h00, 0);
    m_clear();
    #3;
    check_all();

    // Filter checks while held in reset.
    drive(1, 0, 8'h00, 0); #1; chk("flt_nchar", 32'(we_tb), 32'd1);
    drive(0, 1, 8'hFF, 0); #1; chk("flt_esc",   32'(we_tb), 32'd0);
    drive(0, 1, 8'h00, 0); #1; chk("flt_fct",   32'(we_tb), 32'd0);
    drive(0, 1, 8'h02, 0); #1; chk("flt_eep",   32'(we_tb), 32'd1);
    drive(0, 1, 8'h01, 0); #1; chk("flt_eop",   32'(we_tb), 32'd1);
    drive(0, 0, 8'h00, 0);
    @(negedge clk); reset = 1'b1;

    // Fill with nchar, then a 9th push while full.
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 8'(i + 8'h10), 0);
      tick();
    end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_wp",   32'(wp_tb),  32'd0);

    // Drain from full, then drop stb and hold.
    drive(0, 0, 8'h00, 1);
    repeat (3) tick();
    drive(0, 0, 8'h00, 0);
    repeat (3) tick();
    chk("drain_occ", 32'(occupied_tb), 32'hF8);

    // Drain to empty with stb held, plus one extra edge.
    drive(0, 0, 8'h00, 1);
    repeat (7) tick();
    chk("empty_rp", 32'(rp_tb), 32'd0);

    // Concurrent push/pop on a full queue.
    async_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'h55, 0);
      tick();
    end
    drive(1, 0, 8'hAA, 1);
    tick();
    chk("conc_dat0", 32'(bus.dat_o), 32'h155);
    repeat (8) tick();
    chk("conc_dat9", 32'(bus.dat_o), 32'h0AA);
    drive(0, 0, 8'h00, 0);
    tick();
    chk("conc_occ", 32'(occupied_tb), 32'hFE);
    chk("conc_rp",  32'(rp_tb),       32'd1);

    // Push into an empty queue while ack is high.
    async_reset();
    drive(0, 0, 8'h00, 1); tick();
    drive(1, 0, 8'h3C, 1); tick();
    drive(0, 0, 8'h00, 0); repeat (2) tick();

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 5),
            8'($urandom), ($urandom_range(0, 9) < (i < 300 ? 3 : 7)));
      if ($urandom_range(0, 149) == 0) async_reset();
      else tick();
    end

    async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
